// File: rtl/risc_pkg.sv
// Shared types and widths for the RISC datapath.
// Used by the controller, ALU and register-file/write-back stage.
package risc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_RAM  = 2'd1,
        WB_IMM  = 2'd2,
        WB_LINK = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RAM = 2'd1,
        ST_COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/risc_regarray.sv
// Register array: two async read ports, one sync write port.
// R0 reads as zero and ignores writes.
module risc_regarray #(
    parameter int DATA_W = risc_pkg::DATA_W,
    parameter int NREG   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NREG)-1:0]   ra_addr,
    input  logic [$clog2(NREG)-1:0]   rb_addr,
    output logic [DATA_W-1:0]         ra_data,
    output logic [DATA_W-1:0]         rb_data,
    input  logic                      we,
    input  logic [$clog2(NREG)-1:0]   w_addr,
    input  logic [DATA_W-1:0]         w_data
);
    import risc_pkg::*;

    logic [DATA_W-1:0] mem [NREG];

    // Storage: cleared on reset, R0 never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (w_addr != '0)) begin
            mem[w_addr] <= w_data;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/risc_regfile_wb.sv
// Register file + write-back stage: operand reads with bypass,
// write-back select, and a req/ack load engine with timeout.
module risc_regfile_wb #(
    parameter int DATA_W      = risc_pkg::DATA_W,
    parameter int NREG        = 16,
    parameter int OFF_W       = 8,
    parameter int RAM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    input  logic [$clog2(NREG)-1:0]  rs_addr,
    input  logic [$clog2(NREG)-1:0]  rt_addr,
    input  logic                     write_en,
    input  logic                     read_ram,
    input  logic [1:0]               mux_sel,
    input  logic [OFF_W-1:0]         offset,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic [DATA_W-1:0]        ram_rdata,
    input  logic                     ram_ack,
    output logic                     ram_req,
    output logic [DATA_W-1:0]        rs_data,
    output logic [DATA_W-1:0]        rt_data,
    output logic                     z_flag,
    output logic                     busy,
    output logic                     err_timeout,
    output logic                     err_overrun
);
    import risc_pkg::*;

    localparam int AW = $clog2(NREG);
    localparam int TW = $clog2(RAM_TIMEOUT + 1);

    wb_state_t         state;
    logic [AW-1:0]     pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              pend_valid;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] ram_cap;

    logic [DATA_W-1:0] off_ext;
    logic [DATA_W-1:0] wb_value;
    logic [DATA_W-1:0] arr_rs;
    logic [DATA_W-1:0] arr_rt;
    logic              is_load;
    logic              commit_we;

    assign off_ext   = {{(DATA_W-OFF_W){1'b0}}, offset};
    assign is_load   = read_ram && (wb_sel_t'(mux_sel) == WB_RAM);
    assign commit_we = (state == ST_COMMIT) && pend_valid;

    // Write-back source select; immediates are zero-extended.
    always_comb begin
        wb_value = alu_result;
        unique case (wb_sel_t'(mux_sel))
            WB_ALU:  wb_value = alu_result;
            WB_RAM:  wb_value = ram_cap;
            WB_IMM:  wb_value = off_ext;
            WB_LINK: wb_value = off_ext;
        endcase
    end

    risc_regarray #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rs_addr),
        .rb_addr (rt_addr),
        .ra_data (arr_rs),
        .rb_data (arr_rt),
        .we      (commit_we),
        .w_addr  (pend_addr),
        .w_data  (pend_data)
    );

    // Operand reads: a pending write wins over the array.
    always_comb begin
        rs_data = arr_rs;
        rt_data = arr_rt;
        if (pend_valid && (rs_addr != '0) && (pend_addr == rs_addr)) begin
            rs_data = pend_data;
        end
        if (pend_valid && (rt_addr != '0) && (pend_addr == rt_addr)) begin
            rt_data = pend_data;
        end
    end

    // Write-back FSM: commit, accept new writes, run loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pend_addr   <= '0;
            pend_data   <= '0;
            pend_valid  <= 1'b0;
            timer       <= '0;
            ram_cap     <= '0;
            ram_req     <= 1'b0;
            busy        <= 1'b0;
            z_flag      <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_COMMIT: begin
                    if (state == ST_COMMIT) begin
                        z_flag     <= (pend_data == '0);
                        pend_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    if (instr_valid && write_en) begin
                        pend_addr <= rd_addr;
                        if (is_load) begin
                            ram_req <= 1'b1;
                            busy    <= 1'b1;
                            timer   <= '0;
                            state   <= ST_WAIT_RAM;
                        end else begin
                            pend_data  <= wb_value;
                            pend_valid <= 1'b1;
                            state      <= ST_COMMIT;
                        end
                    end
                end
                ST_WAIT_RAM: begin
                    if (instr_valid) begin
                        err_overrun <= 1'b1;
                    end
                    if (ram_ack) begin
                        ram_cap    <= ram_rdata;
                        pend_data  <= ram_rdata;
                        pend_valid <= 1'b1;
                        ram_req    <= 1'b0;
                        state      <= ST_COMMIT;
                    end else if (timer == TW'(RAM_TIMEOUT)) begin
                        ram_req     <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
